// File: rtl/exec_wb_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exec_pkg
//  Description : Shared opcode and FSM state encodings for the execute /
//                writeback stage, plus carry-register and multiplier constants.
//  Contents    : op_e     - 4-bit opcode (values 11..15 are undefined ops)
//                state_e  - exec_wb_unit control states
//                CAR_REG  - regfile index that receives the carry / high byte
//                MUL_CYCLES - iterations of the sequential multiplier
//  Revision    : 1.0  initial release
// ============================================================================
package exec_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_ADC = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_MUL = 4'd8,
        OP_CLR = 4'd9,
        OP_MOV = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    localparam int CAR_REG    = 12;
    localparam int MUL_CYCLES = 8;

endpackage : exec_pkg
`default_nettype wire

// File: rtl/exec_wb_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : exec_wb_unit_if
//  Description : Issue and writeback bundle between the decoder, the
//                execute/writeback stage and the register file.
//  Signals     : start/op/dst_addr/rs_val/rt_val/car_val  - issue side
//                busy/done                                 - status
//                reg_write/reg_clear/rd_addr/rd_in         - regfile write port
//                car_write/car_in                          - carry register port
//  Modports    : master - issuer (drives operands, observes results)
//                slave  - exec_wb_unit
//  Revision    : 1.0  initial release
// ============================================================================
interface exec_wb_unit_if #(
    parameter int REG_WIDTH = 8,
    parameter int NUM_REGS  = 13
);
    import exec_pkg::*;

    localparam int ADDR_W = $clog2(NUM_REGS);

    logic                 start;
    op_e                  op;
    logic [ADDR_W-1:0]    dst_addr;
    logic [REG_WIDTH-1:0] rs_val;
    logic [REG_WIDTH-1:0] rt_val;
    logic [REG_WIDTH-1:0] car_val;

    logic                 busy;
    logic                 done;
    logic                 reg_write;
    logic                 reg_clear;
    logic [ADDR_W-1:0]    rd_addr;
    logic [REG_WIDTH-1:0] rd_in;
    logic                 car_write;
    logic [REG_WIDTH-1:0] car_in;

    modport master (
        output start, op, dst_addr, rs_val, rt_val, car_val,
        input  busy, done, reg_write, reg_clear, rd_addr, rd_in, car_write, car_in
    );

    modport slave (
        input  start, op, dst_addr, rs_val, rt_val, car_val,
        output busy, done, reg_write, reg_clear, rd_addr, rd_in, car_write, car_in
    );

endinterface : exec_wb_unit_if
`default_nettype wire

// File: rtl/exec_wb_unit_mul8_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mul8_seq
//  Description : Unsigned shift-add multiplier, one partial product per clock.
//                load latches a/b; WIDTH iterations follow. done is high
//                during the final iteration and product then carries the
//                completed result (the value about to be accumulated), so the
//                consumer can register it on the same edge.
//  Ports       : clk, rst_n (async active-low), load, a, b
//                busy (iterating), done, product[2*WIDTH-1:0]
//  Revision    : 1.0  initial release
// ============================================================================
module mul8_seq
    import exec_pkg::*;
#(
    parameter int WIDTH = MUL_CYCLES
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 load,
    input  wire logic [WIDTH-1:0]     a,
    input  wire logic [WIDTH-1:0]     b,
    output logic                      busy,
    output logic                      done,
    output logic [2*WIDTH-1:0]        product
);

    localparam int             CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;

    logic [2*WIDTH-1:0] w_acc_nxt;

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (load) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt + CW'(1);
            if (r_cnt == C_LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_busy && (r_cnt == C_LAST);
    assign product = w_acc_nxt;

endmodule : mul8_seq
`default_nettype wire

// File: rtl/exec_wb_unit.sv
`default_nettype none
// ============================================================================
//  Module      : exec_wb_unit
//  Description : Execute/writeback stage feeding a 13x8 register file.
//                Single-cycle ALU ops write back one cycle after issue;
//                MUL runs on mul8_seq and writes back after 8 iterations,
//                low byte to rd and high byte to the carry register.
//                Every output is registered; strobes are only high in WB.
//  Ports       : clk, rst_n (async assert, active-low)
//                bus - exec_wb_unit_if.slave (issue, status, write ports)
//  Revision    : 1.0  initial release
// ============================================================================
module exec_wb_unit #(
    parameter int REG_WIDTH = 8,
    parameter int NUM_REGS  = 13
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    exec_wb_unit_if.slave   bus
);
    import exec_pkg::*;

    localparam int ADDR_W = $clog2(NUM_REGS);

    // Registered state and outputs
    state_e               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_reg_write;
    logic                 r_reg_clear;
    logic                 r_car_write;
    logic [ADDR_W-1:0]    r_rd_addr;
    logic [REG_WIDTH-1:0] r_rd_in;
    logic [REG_WIDTH-1:0] r_car_in;

    // Next-state values
    state_e               w_state_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic                 w_reg_write_nxt;
    logic                 w_reg_clear_nxt;
    logic                 w_car_write_nxt;
    logic [ADDR_W-1:0]    w_rd_addr_nxt;
    logic [REG_WIDTH-1:0] w_rd_in_nxt;
    logic [REG_WIDTH-1:0] w_car_in_nxt;

    // ALU and multiplier datapath
    logic                   w_cin;
    logic [REG_WIDTH:0]     w_sum;
    logic [REG_WIDTH:0]     w_diff;
    logic                   w_mul_load;
    logic                   w_mul_done;
    logic                   w_mul_busy_unused;
    logic [2*REG_WIDTH-1:0] w_mul_product;
    logic                   w_unused_car;

    // Only bit 0 of the carry register participates in arithmetic.
    assign w_cin        = bus.car_val[0];
    assign w_unused_car = ^bus.car_val[REG_WIDTH-1:1];

    assign w_sum  = {1'b0, bus.rs_val} + {1'b0, bus.rt_val}
                  + {{REG_WIDTH{1'b0}}, (bus.op == OP_ADC) ? w_cin : 1'b0};
    assign w_diff = {1'b0, bus.rs_val} - {1'b0, bus.rt_val};

    mul8_seq #(
        .WIDTH   (REG_WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_mul_load),
        .a       (bus.rs_val),
        .b       (bus.rt_val),
        .busy    (w_mul_busy_unused),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_reg_write <= 1'b0;
            r_reg_clear <= 1'b0;
            r_car_write <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_in     <= '0;
            r_car_in    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_reg_write <= w_reg_write_nxt;
            r_reg_clear <= w_reg_clear_nxt;
            r_car_write <= w_car_write_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            r_rd_in     <= w_rd_in_nxt;
            r_car_in    <= w_car_in_nxt;
        end
    end

    // Results are computed straight from the issue inputs and registered on
    // the accepting edge, so capture of the operands and the writeback
    // register are the same flops for single-cycle ops.
    always_comb begin
        w_state_nxt     = r_state;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_reg_write_nxt = 1'b0;
        w_reg_clear_nxt = 1'b0;
        w_car_write_nxt = 1'b0;
        w_rd_addr_nxt   = r_rd_addr;
        w_rd_in_nxt     = r_rd_in;
        w_car_in_nxt    = r_car_in;
        w_mul_load      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_busy_nxt    = 1'b1;
                    w_rd_addr_nxt = bus.dst_addr;
                    if (bus.op == OP_MUL) begin
                        w_state_nxt = ST_MUL;
                        w_mul_load  = 1'b1;
                    end else begin
                        w_state_nxt = ST_WB;
                        w_done_nxt  = 1'b1;
                        case (bus.op)
                            OP_ADD, OP_ADC: begin
                                w_reg_write_nxt = 1'b1;
                                w_car_write_nxt = 1'b1;
                                w_rd_in_nxt     = w_sum[REG_WIDTH-1:0];
                                w_car_in_nxt    = {{(REG_WIDTH-1){1'b0}}, w_sum[REG_WIDTH]};
                            end
                            OP_SUB: begin
                                w_reg_write_nxt = 1'b1;
                                w_car_write_nxt = 1'b1;
                                w_rd_in_nxt     = w_diff[REG_WIDTH-1:0];
                                w_car_in_nxt    = {{(REG_WIDTH-1){1'b0}}, w_diff[REG_WIDTH]};
                            end
                            OP_AND: begin
                                w_reg_write_nxt = 1'b1;
                                w_rd_in_nxt     = bus.rs_val & bus.rt_val;
                            end
                            OP_OR: begin
                                w_reg_write_nxt = 1'b1;
                                w_rd_in_nxt     = bus.rs_val | bus.rt_val;
                            end
                            OP_XOR: begin
                                w_reg_write_nxt = 1'b1;
                                w_rd_in_nxt     = bus.rs_val ^ bus.rt_val;
                            end
                            OP_SHL: begin
                                w_reg_write_nxt = 1'b1;
                                w_car_write_nxt = 1'b1;
                                w_rd_in_nxt     = {bus.rs_val[REG_WIDTH-2:0], w_cin};
                                w_car_in_nxt    = {{(REG_WIDTH-1){1'b0}}, bus.rs_val[REG_WIDTH-1]};
                            end
                            OP_SHR: begin
                                w_reg_write_nxt = 1'b1;
                                w_car_write_nxt = 1'b1;
                                w_rd_in_nxt     = {w_cin, bus.rs_val[REG_WIDTH-1:1]};
                                w_car_in_nxt    = {{(REG_WIDTH-1){1'b0}}, bus.rs_val[0]};
                            end
                            OP_CLR: begin
                                w_reg_write_nxt = 1'b1;
                                w_reg_clear_nxt = 1'b1;
                                w_rd_in_nxt     = '0;
                            end
                            OP_MOV: begin
                                w_reg_write_nxt = 1'b1;
                                w_rd_in_nxt     = bus.rs_val;
                            end
                            default: begin
                                // Undefined opcode: completes with done only.
                            end
                        endcase
                    end
                end
            end

            ST_MUL: begin
                if (w_mul_done) begin
                    w_state_nxt     = ST_WB;
                    w_done_nxt      = 1'b1;
                    w_reg_write_nxt = 1'b1;
                    w_car_write_nxt = 1'b1;
                    w_rd_in_nxt     = w_mul_product[REG_WIDTH-1:0];
                    w_car_in_nxt    = w_mul_product[2*REG_WIDTH-1:REG_WIDTH];
                end
            end

            ST_WB: begin
                // start is deliberately not sampled here.
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.reg_write = r_reg_write;
    assign bus.reg_clear = r_reg_clear;
    assign bus.car_write = r_car_write;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.rd_in     = r_rd_in;
    assign bus.car_in    = r_car_in;

endmodule : exec_wb_unit
`default_nettype wire

// File: tb/tb_exec_wb_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_wb_unit
//  Description : Directed self-checking bench for exec_wb_unit. Inputs are
//                driven and outputs sampled on the falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_exec_wb_unit;
    import exec_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    exec_wb_unit_if bus ();

    exec_wb_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge with the DUT idle; returns on the falling edge
    // of the first cycle after acceptance, with operands scrambled.
    task automatic issue(input op_e op, input logic [3:0] dst,
                         input logic [7:0] rs, input logic [7:0] rt, input logic [7:0] cv);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.dst_addr = dst;
        bus.rs_val   = rs;
        bus.rt_val   = rt;
        bus.car_val  = cv;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.rs_val   = 8'h5A;
        bus.rt_val   = 8'hA5;
        bus.car_val  = 8'hFE;
        bus.dst_addr = 4'hB;
    endtask

    initial begin
        logic bad;
        int   cnt;
        logic [7:0] cap_rd;
        logic [7:0] cap_car;
        logic [3:0] cap_addr;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.start    = 1'b0;
        bus.op       = OP_ADD;
        bus.dst_addr = '0;
        bus.rs_val   = '0;
        bus.rt_val   = '0;
        bus.car_val  = '0;
        cap_rd = '0; cap_car = '0; cap_addr = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy",  bus.busy,      0);
        chk("rst_done",  bus.done,      0);
        chk("rst_rw",    bus.reg_write, 0);
        chk("rst_clr",   bus.reg_clear, 0);
        chk("rst_cw",    bus.car_write, 0);
        chk("rst_addr",  bus.rd_addr,   0);
        chk("rst_rdin",  bus.rd_in,     0);
        chk("rst_carin", bus.car_in,    0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD F0+20 -> 10, carry 1
        issue(OP_ADD, 4'd3, 8'hF0, 8'h20, 8'h00);
        chk("add_rw",    bus.reg_write, 1);
        chk("add_cw",    bus.car_write, 1);
        chk("add_addr",  bus.rd_addr,   3);
        chk("add_rdin",  bus.rd_in,     16'h10);
        chk("add_carin", bus.car_in,    16'h01);
        chk("add_done",  bus.done,      1);
        chk("add_busy",  bus.busy,      1);
        chk("add_clr",   bus.reg_clear, 0);
        @(negedge clk);
        chk("add_rw_off",   bus.reg_write, 0);
        chk("add_done_off", bus.done,      0);
        chk("add_busy_off", bus.busy,      0);

        // MUL FF*FF = FE01
        issue(OP_MUL, 4'd5, 8'hFF, 8'hFF, 8'h00);
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bad |= bus.reg_write | bus.car_write | bus.done | ~bus.busy;
            @(negedge clk);
        end
        chk("mul_iter_quiet", bad, 0);
        chk("mul_rw",    bus.reg_write, 1);
        chk("mul_cw",    bus.car_write, 1);
        chk("mul_addr",  bus.rd_addr,   5);
        chk("mul_rdin",  bus.rd_in,     16'h01);
        chk("mul_carin", bus.car_in,    16'hFE);
        chk("mul_done",  bus.done,      1);
        @(negedge clk);
        chk("mul_done_off", bus.done, 0);
        chk("mul_busy_off", bus.busy, 0);

        // SUB 05-07 -> FE with borrow
        issue(OP_SUB, 4'd1, 8'h05, 8'h07, 8'h00);
        chk("sub_rdin",  bus.rd_in,  16'hFE);
        chk("sub_carin", bus.car_in, 16'h01);
        chk("sub_cw",    bus.car_write, 1);
        @(negedge clk);

        // ADC FF+00+1 -> 00 carry 1
        issue(OP_ADC, 4'd2, 8'hFF, 8'h00, 8'h01);
        chk("adc_rdin",  bus.rd_in,  16'h00);
        chk("adc_carin", bus.car_in, 16'h01);
        @(negedge clk);

        // XOR: no carry write
        issue(OP_XOR, 4'd4, 8'hA5, 8'h0F, 8'h01);
        chk("xor_rdin", bus.rd_in,     16'hAA);
        chk("xor_cw",   bus.car_write, 0);
        chk("xor_rw",   bus.reg_write, 1);
        @(negedge clk);

        // SHR 03 with carry-in 1 -> 81, carry-out 1
        issue(OP_SHR, 4'd6, 8'h03, 8'h00, 8'h01);
        chk("shr_rdin",  bus.rd_in,  16'h81);
        chk("shr_carin", bus.car_in, 16'h01);
        @(negedge clk);

        // ADD into reg 12: both strobes
        issue(OP_ADD, 4'd12, 8'h7F, 8'h01, 8'h00);
        chk("add12_rw",    bus.reg_write, 1);
        chk("add12_cw",    bus.car_write, 1);
        chk("add12_addr",  bus.rd_addr,   12);
        chk("add12_rdin",  bus.rd_in,     16'h80);
        chk("add12_carin", bus.car_in,    16'h00);
        @(negedge clk);

        // Undefined opcode: done only
        issue(op_e'(4'hE), 4'd7, 8'h12, 8'h34, 8'h00);
        chk("undef_done", bus.done,      1);
        chk("undef_rw",   bus.reg_write, 0);
        chk("undef_cw",   bus.car_write, 0);
        @(negedge clk);

        // start held every cycle: ALU accepted every second cycle
        bus.start = 1'b1; bus.op = OP_ADD; bus.dst_addr = 4'd8;
        bus.rs_val = 8'h01; bus.rt_val = 8'h01; bus.car_val = 8'h00;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.reg_write) cnt++;
        end
        bus.start = 1'b0;
        chk("b2b_count", 16'(cnt), 3);
        @(negedge clk);
        chk("b2b_idle", bus.busy, 0);

        // start held during MUL: ignored until MUL completes
        issue(OP_MUL, 4'd7, 8'h03, 8'h05, 8'h00);
        bus.start = 1'b1; bus.op = OP_ADD; bus.dst_addr = 4'd9;
        bus.rs_val = 8'h11; bus.rt_val = 8'h22;
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            if (bus.reg_write) begin
                cnt++;
                cap_rd   = bus.rd_in;
                cap_car  = bus.car_in;
                cap_addr = bus.rd_addr;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("mulhold_count", 16'(cnt), 1);
        chk("mulhold_rdin",  cap_rd,   16'h0F);
        chk("mulhold_carin", cap_car,  16'h00);
        chk("mulhold_addr",  cap_addr, 7);
        chk("mulhold_busy",  bus.busy, 0);
        @(negedge clk);
        chk("mulhold_no_extra", bus.reg_write, 0);

        // Reset during MUL iteration 4
        issue(OP_MUL, 4'd4, 8'hFF, 8'hFF, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  bus.busy,    0);
        chk("abort_rdin",  bus.rd_in,   0);
        chk("abort_carin", bus.car_in,  0);
        chk("abort_addr",  bus.rd_addr, 0);
        chk("abort_done",  bus.done,    0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bad |= bus.reg_write | bus.car_write | bus.done;
            @(negedge clk);
        end
        chk("abort_no_write", bad, 0);

        // CLR to r0
        issue(OP_CLR, 4'd0, 8'h33, 8'h44, 8'h00);
        chk("clr_rw",   bus.reg_write, 1);
        chk("clr_clr",  bus.reg_clear, 1);
        chk("clr_rdin", bus.rd_in,     0);
        chk("clr_addr", bus.rd_addr,   0);
        chk("clr_cw",   bus.car_write, 0);
        @(negedge clk);
        chk("clr_off",  bus.reg_clear, 0);

        // SHL 81 with carry-in 0 -> 02, carry-out 1
        issue(OP_SHL, 4'd2, 8'h81, 8'h00, 8'h00);
        chk("shl_rdin",  bus.rd_in,     16'h02);
        chk("shl_carin", bus.car_in,    16'h01);
        chk("shl_cw",    bus.car_write, 1);
        chk("shl_clr",   bus.reg_clear, 0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_exec_wb_unit
`default_nettype wire
